// File: rtl/crc_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crc_job_arbiter
// Description : Round-robin arbiter that shares one CRC-16/USB engine and its
//               synchronous job ROM between N_REQ requesters. Sequences engine
//               clear, memory fetch and engine enable for the granted job and
//               returns the CRC through a valid/ready done handshake.
//               Optional macro CRC_ERR_CNT_EN adds a saturating error counter
//               (err_cnt) of accepted reports whose CRC missed the target.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_job_arbiter #(
    parameter int  N_REQ  = 4,
    parameter int  ADDR_W = 10,
    parameter int  LEN_W  = 10,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk50m,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*16-1:0]     req_target,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [7:0]              mem_data,
    output logic                    crc_clr,
    output logic                    crc_en,
    input  logic [15:0]             crc_value,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [ID_W-1:0]         done_id,
    output logic [15:0]             done_crc,
    output logic                    done_ok,
`ifdef CRC_ERR_CNT_EN
    output logic [15:0]             err_cnt,
`endif
    output logic                    busy
);

    localparam logic [2:0]      c_IDLE    = 3'd0;
    localparam logic [2:0]      c_CLEAR   = 3'd1;
    localparam logic [2:0]      c_FETCH   = 3'd2;
    localparam logic [2:0]      c_WAIT    = 3'd3;
    localparam logic [2:0]      c_REPORT  = 3'd4;
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

    logic [2:0]        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [LEN_W-1:0]  r_cnt;
    logic [15:0]       r_target;

    logic [ID_W-1:0]   w_scan;
    logic [ID_W-1:0]   w_gidx;
    logic              w_found;
    logic [N_REQ-1:0]  w_grant_oh;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;
    logic [15:0]       w_sel_tgt;

    // ROM data feeds the engine directly; the arbiter only drives the address.
    logic              w_unused_mem_data;
    assign w_unused_mem_data = ^mem_data;

    // Round-robin search: first pending requester after the last grant, wrapping.
    always_comb begin
        w_scan  = r_ptr;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan = (w_scan == c_LAST_ID) ? '0 : w_scan + ID_W'(1);
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_gidx  = w_scan;
            end
        end
    end

    // Pick the job descriptor of the winning requester out of the packed buses.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_tgt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gidx == ID_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = req_len[i*LEN_W +: LEN_W];
                w_sel_tgt  = req_target[i*16 +: 16];
            end
        end
    end

    assign w_grant_oh = N_REQ'(1) << w_gidx;

    // Job sequencer: grant, clear engine, stream bytes, let engine settle, report.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_ptr      <= c_LAST_ID;
            r_id       <= '0;
            r_cnt      <= '0;
            r_target   <= '0;
            req_ready  <= '0;
            mem_addr   <= '0;
            crc_clr    <= 1'b0;
            crc_en     <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_crc   <= '0;
            done_ok    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state   <= c_CLEAR;
                        r_ptr     <= w_gidx;
                        r_id      <= w_gidx;
                        r_cnt     <= w_sel_len;
                        r_target  <= w_sel_tgt;
                        req_ready <= w_grant_oh;
                        crc_clr   <= 1'b1;
                        mem_addr  <= w_sel_addr;
                        busy      <= 1'b1;
                    end
                end
                c_CLEAR: begin
                    req_ready <= '0;
                    crc_clr   <= 1'b0;
                    if (r_cnt == '0) begin
                        // Nothing to stream: the engine already holds its seed.
                        r_state <= c_WAIT;
                    end else begin
                        r_state  <= c_FETCH;
                        crc_en   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                c_FETCH: begin
                    // mem_data this cycle belongs to the address issued last cycle.
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= c_WAIT;
                        crc_en  <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                c_WAIT: begin
                    // crc_value now reflects the last consumed byte.
                    r_state    <= c_REPORT;
                    done_valid <= 1'b1;
                    done_id    <= r_id;
                    done_crc   <= crc_value;
                    done_ok    <= (crc_value == r_target);
                end
                c_REPORT: begin
                    if (done_ready) begin
                        r_state    <= c_IDLE;
                        done_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    req_ready  <= '0;
                    crc_clr    <= 1'b0;
                    crc_en     <= 1'b0;
                    done_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of accepted reports whose CRC did not match the target.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (done_valid && done_ready && !done_ok && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_job_arbiter
// Description : Scoreboard bench for crc_job_arbiter with a behavioural
//               synchronous ROM and CRC-16/USB engine attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_job_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int ID_W   = 2;

    logic                    clk50m = 1'b0;
    logic                    rst_n  = 1'b0;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ*16-1:0]     req_target;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_data;
    logic                    crc_clr;
    logic                    crc_en;
    logic [15:0]             crc_value;
    logic                    done_valid;
    logic                    done_ready;
    logic [ID_W-1:0]         done_id;
    logic [15:0]             done_crc;
    logic                    done_ok;
    logic                    busy;
`ifdef CRC_ERR_CNT_EN
    logic [15:0]             err_cnt;
`endif

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     crc;
        logic            ok;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          en_cycles = 0;
    logic [7:0]  rom [0:1023];
    logic [15:0] eng_s;

    crc_job_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_target (req_target),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .crc_clr    (crc_clr),
        .crc_en     (crc_en),
        .crc_value  (crc_value),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .done_crc   (done_crc),
        .done_ok    (done_ok),
`ifdef CRC_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .busy       (busy)
    );

    always #10 clk50m = ~clk50m;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Reference CRC over ROM bytes; an empty job reports the seed.
    function automatic logic [15:0] crc_ref(input int addr, input int len);
        logic [15:0] s;
        if (len == 0) return 16'hFFFF;
        s = 16'hFFFF;
        for (int k = 0; k < len; k++) begin
            s = crc_step(s, rom[(addr + k) % 1024]);
        end
        return ~s;
    endfunction

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk50m) mem_data <= rom[mem_addr];

    // Behavioural engine: clear loads the seed, each enable folds in one byte.
    always @(posedge clk50m) begin
        if (crc_clr) begin
            eng_s     <= 16'hFFFF;
            crc_value <= 16'hFFFF;
        end else if (crc_en) begin
            eng_s     <= crc_step(eng_s, mem_data);
            crc_value <= ~crc_step(eng_s, mem_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic queue_job(input int i, input int addr, input int len,
                             input logic [15:0] tgt, input logic [15:0] exp_crc);
        exp_t e;
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        req_len[i*LEN_W +: LEN_W]    = LEN_W'(len);
        req_target[i*16 +: 16]       = tgt;
        e.id  = ID_W'(i);
        e.crc = exp_crc;
        e.ok  = (exp_crc == tgt);
        sb_q.push_back(e);
    endtask

    // Returns on the negedge where the last requester in mask was accepted.
    task automatic wait_accept(input logic [N_REQ-1:0] mask);
        logic [N_REQ-1:0] pend;
        int t;
        pend = mask;
        t    = 0;
        while (pend != 0 && t < 300) begin
            @(negedge clk50m);
            t++;
            if (req_ready != 0) begin
                check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                pend      = pend & ~req_ready;
                req_valid = req_valid & ~req_ready;
            end
        end
        if (pend != 0) check("accept_timeout", 64'(pend), 64'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || done_valid || sb_q.size() != 0) && t < 400) begin
            @(negedge clk50m);
            t++;
        end
        if (t >= 400) check("idle_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk50m);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk50m);
            #1;
            if (crc_en) en_cycles++;
            if (rst_n && done_valid && done_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done_id), 64'hFF);
                end else begin
                    e = sb_q.pop_front();
                    check("done_id", 64'(done_id), 64'(e.id));
                    check("done_crc", 64'(done_crc), 64'(e.crc));
                    check("done_ok", 64'(done_ok), 64'(e.ok));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int lat;
        int en0;
        for (int a = 0; a < 1024; a++) rom[a] = 8'(a * 7 + 3);
        for (int a = 0; a < 9; a++) rom[a] = 8'(8'h31 + a);
        req_valid  = '0;
        req_addr   = '0;
        req_len    = '0;
        req_target = '0;
        done_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk50m);
        check("reset_outputs",
              64'({req_ready, mem_addr, crc_clr, crc_en, done_valid, done_id, done_crc, done_ok, busy}),
              64'd0);
        rst_n = 1'b1;
        @(negedge clk50m);

        // Check-string job, consumer stalls for a few cycles before accepting.
        done_ready = 1'b0;
        queue_job(0, 0, 9, 16'hB4C8, 16'hB4C8);
        req_valid[0] = 1'b1;
        wait_accept(4'b0001);
        lat = 0;
        while (!done_valid && lat < 30) begin
            @(negedge clk50m);
            lat++;
        end
        check("done_latency", 64'(lat), 64'd11);
        repeat (3) @(negedge clk50m);
        check("done_hold_valid", 64'(done_valid), 64'd1);
        check("done_hold_crc", 64'(done_crc), 64'hB4C8);
        done_ready = 1'b1;
        wait_idle();

        // Same data, wrong target.
        queue_job(0, 0, 9, 16'h0000, 16'hB4C8);
        req_valid[0] = 1'b1;
        wait_accept(4'b0001);
        wait_idle();
`ifdef CRC_ERR_CNT_EN
        check("err_cnt", 64'(err_cnt), 64'd1);
`endif

        // All four at once: round-robin from the last grant (0) gives 1,2,3,0?
        // No: pointer is 0 after the previous jobs, so order is 1,2,3,0.
        for (int i = 1; i < 4; i++) queue_job(i, 16 + i, 1, crc_ref(16 + i, 1), crc_ref(16 + i, 1));
        queue_job(0, 16, 1, crc_ref(16, 1), crc_ref(16, 1));
        req_valid = 4'b1111;
        wait_accept(4'b1111);
        wait_idle();

        // Pointer now sits at 0; requesters 0 and 3 together -> 3 then 0.
        queue_job(3, 40, 2, 16'h1234, crc_ref(40, 2));
        queue_job(0, 50, 1, crc_ref(50, 1), crc_ref(50, 1));
        req_valid = 4'b1001;
        wait_accept(4'b1001);
        wait_idle();

        // Pointer at 0 again; requesters 0 and 2 together -> 2 then 0.
        queue_job(2, 60, 3, crc_ref(60, 3), crc_ref(60, 3));
        queue_job(0, 70, 1, crc_ref(70, 1), crc_ref(70, 1));
        req_valid = 4'b0101;
        wait_accept(4'b0101);
        wait_idle();

        // Address wrap at the top of memory.
        en0 = en_cycles;
        queue_job(2, 10'h3FE, 4, crc_ref(10'h3FE, 4), crc_ref(10'h3FE, 4));
        req_valid[2] = 1'b1;
        wait_accept(4'b0100);
        check("wrap_addr0", 64'(mem_addr), 64'h3FE);
        @(negedge clk50m);
        check("wrap_addr1", 64'(mem_addr), 64'h3FF);
        @(negedge clk50m);
        check("wrap_addr2", 64'(mem_addr), 64'h000);
        @(negedge clk50m);
        check("wrap_addr3", 64'(mem_addr), 64'h001);
        wait_idle();
        check("wrap_en_cycles", 64'(en_cycles - en0), 64'd4);

        // Empty job reports the seed with no enables.
        en0 = en_cycles;
        queue_job(3, 5, 0, 16'hFFFF, 16'hFFFF);
        req_valid[3] = 1'b1;
        wait_accept(4'b1000);
        wait_idle();
        check("len0_en_cycles", 64'(en_cycles - en0), 64'd0);

        // Reset in the middle of streaming; the requester keeps asking.
        queue_job(1, 0, 9, 16'hB4C8, 16'hB4C8);
        req_valid[1] = 1'b1;
        wait_accept(4'b0010);
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk50m);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              64'({req_ready, mem_addr, crc_clr, crc_en, done_valid, done_id, done_crc, done_ok, busy}),
              64'd0);
        @(negedge clk50m);
        rst_n = 1'b1;
        wait_accept(4'b0010);
        wait_idle();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
